// File: rtl/core_pkg.sv
// Shared core definitions: register-file geometry, register address type and writeback source encodings.
package core_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    ALU_SRC = 2'd0,
    MEM_SRC = 2'd1,
    PC_SRC  = 2'd2
  } reg_src_t;

  function automatic logic is_x0(input reg_addr_t addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/reg_file_wb_if.sv
// Writeback, issue and read-port bundle between the pipeline (master) and the register file (slave).
interface reg_file_wb_if #(
  parameter int XLEN  = core_pkg::XLEN,
  parameter int CNT_W = 32
);

  logic                 regWrite;
  core_pkg::reg_addr_t  rdAddr;
  logic [XLEN-1:0]      result;

  core_pkg::reg_addr_t  rs1Addr;
  core_pkg::reg_addr_t  rs2Addr;
  logic [XLEN-1:0]      rs1Data;
  logic [XLEN-1:0]      rs2Data;

  logic                 issueValid;
  core_pkg::reg_addr_t  issueRd;
  logic                 flush;
  logic                 rs1Busy;
  logic                 rs2Busy;
  logic                 issueStall;

  logic [CNT_W-1:0]     wbCount;

  modport master (
    output regWrite, rdAddr, result,
    output rs1Addr, rs2Addr,
    output issueValid, issueRd, flush,
    input  rs1Data, rs2Data,
    input  rs1Busy, rs2Busy, issueStall,
    input  wbCount
  );

  modport slave (
    input  regWrite, rdAddr, result,
    input  rs1Addr, rs2Addr,
    input  issueValid, issueRd, flush,
    output rs1Data, rs2Data,
    output rs1Busy, rs2Busy, issueStall,
    output wbCount
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters with busy/stall outputs; combinational outputs, updates on clk.
// Backpressure via issueStall when a counter saturates; REGFILE_WB_BYPASS_EN clears busy on the resolving write.
module reg_scoreboard
  import core_pkg::*;
#(
  parameter int PEND_W = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      issue_valid,
  input  reg_addr_t issue_rd,
  input  logic      flush,
  input  logic      wb_en,
  input  reg_addr_t wb_rd,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  output logic      rs1_busy,
  output logic      rs2_busy,
  output logic      issue_stall
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [NUM_REGS-1:0][PEND_W-1:0] pend;
  logic inc;
  logic dec;
  logic same_reg;

  assign issue_stall = issue_valid && !is_x0(issue_rd) && (pend[issue_rd] == PEND_MAX);
  assign inc         = issue_valid && !is_x0(issue_rd) && !issue_stall && !flush;
  // A writeback with nothing pending (e.g. after flush) must not underflow.
  assign dec         = wb_en && !is_x0(wb_rd) && (pend[wb_rd] != '0);
  assign same_reg    = inc && dec && (issue_rd == wb_rd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else if (flush) begin
      pend <= '0;
    end else if (!same_reg) begin
      if (inc) pend[issue_rd] <= pend[issue_rd] + PEND_ONE;
      if (dec) pend[wb_rd]    <= pend[wb_rd] - PEND_ONE;
    end
  end

  function automatic logic busy_of(input reg_addr_t addr);
    logic busy;
    busy = !is_x0(addr) && (pend[addr] != '0);
`ifdef REGFILE_WB_BYPASS_EN
    // The last outstanding write is landing now and its data is forwarded.
    if (wb_en && !is_x0(wb_rd) && (wb_rd == addr) && (pend[addr] == PEND_ONE)) busy = 1'b0;
`endif
    return busy;
  endfunction

  always_comb begin
    rs1_busy = busy_of(rs1_addr);
    rs2_busy = busy_of(rs2_addr);
  end

endmodule

// File: rtl/reg_file_wb.sv
// 32 x XLEN register file terminating writeback: 2 combinational reads, write visible after the edge.
// REGFILE_WB_BYPASS_EN forwards the writeback result to matching reads in the same cycle.
module reg_file_wb #(
  parameter int XLEN   = core_pkg::XLEN,
  parameter int PEND_W = 2,
  parameter int CNT_W  = 32
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_wb_if.slave bus
);

  import core_pkg::*;

  logic [XLEN-1:0]  regs [NUM_REGS];
  logic [CNT_W-1:0] wb_count;
  logic             wr_fire;
  logic [XLEN-1:0]  rs1_val;
  logic [XLEN-1:0]  rs2_val;

  assign wr_fire = bus.regWrite && !is_x0(bus.rdAddr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wb_count <= '0;
    end else if (wr_fire) begin
      regs[bus.rdAddr] <= bus.result;
      wb_count         <= wb_count + 1'b1;
    end
  end

  always_comb begin
    rs1_val = is_x0(bus.rs1Addr) ? '0 : regs[bus.rs1Addr];
    rs2_val = is_x0(bus.rs2Addr) ? '0 : regs[bus.rs2Addr];
`ifdef REGFILE_WB_BYPASS_EN
    // Reset holds reads at zero even if a write is presented meanwhile.
    if (!rst && wr_fire && (bus.rdAddr == bus.rs1Addr)) rs1_val = bus.result;
    if (!rst && wr_fire && (bus.rdAddr == bus.rs2Addr)) rs2_val = bus.result;
`endif
  end

  assign bus.rs1Data = rs1_val;
  assign bus.rs2Data = rs2_val;
  assign bus.wbCount = wb_count;

  reg_scoreboard #(
    .PEND_W (PEND_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (bus.issueValid),
    .issue_rd    (bus.issueRd),
    .flush       (bus.flush),
    .wb_en       (bus.regWrite),
    .wb_rd       (bus.rdAddr),
    .rs1_addr    (bus.rs1Addr),
    .rs2_addr    (bus.rs2Addr),
    .rs1_busy    (bus.rs1Busy),
    .rs2_busy    (bus.rs2Busy),
    .issue_stall (bus.issueStall)
  );

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: vector table through an expect queue plus hazard/flush/reset sequences.
`timescale 1ns/1ps
module tb_reg_file_wb;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reg_file_wb_if bus ();

  reg_file_wb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] dat;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ecnt;
  } vec_t;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ecnt;
    int          idx;
  } exp_t;

  vec_t        tbl [8];
  exp_t        expq [$];
  exp_t        ex;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.regWrite   = 1'b0;
    bus.issueValid = 1'b0;
    bus.flush      = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    bus.regWrite = 1'b1;
    bus.rdAddr   = rd;
    bus.result   = d;
    if (rd != 5'd0) exp_cnt = exp_cnt + 1;
  endtask

  task automatic issue(input logic [4:0] rd);
    bus.issueValid = 1'b1;
    bus.issueRd    = rd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        32'd1};
    tbl[1] = '{1'b1, 5'd0,  32'h00001234, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'd1};
    tbl[2] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2};
    tbl[3] = '{1'b0, 5'd5,  32'h0,        5'd5,  5'd31, 32'hDEADBEEF, 32'hFFFFFFFF, 32'd2};
    tbl[4] = '{1'b1, 5'd5,  32'h0,        5'd5,  5'd1,  32'h0,        32'h0,        32'd3};
    tbl[5] = '{1'b1, 5'd1,  32'h00000001, 5'd1,  5'd5,  32'h1,        32'h0,        32'd4};
    tbl[6] = '{1'b1, 5'd17, 32'hA5A5A5A5, 5'd17, 5'd1,  32'hA5A5A5A5, 32'h1,        32'd5};
    tbl[7] = '{1'b0, 5'd17, 32'h00000123, 5'd31, 5'd17, 32'hFFFFFFFF, 32'hA5A5A5A5, 32'd5};

    idle();
    bus.rdAddr  = 5'd0;
    bus.result  = 32'h0;
    bus.rs1Addr = 5'd5;
    bus.rs2Addr = 5'd7;
    bus.issueRd = 5'd0;

    // Reset state, with an issue presented so issueStall is exercised.
    #1 rst = 1'b1;
    issue(5'd7);
    #11;
    chk("rst_rs1Data", bus.rs1Data, 32'h0);
    chk("rst_rs2Data", bus.rs2Data, 32'h0);
    chk("rst_rs1Busy", 32'(bus.rs1Busy), 32'h0);
    chk("rst_issueStall", 32'(bus.issueStall), 32'h0);
    chk("rst_wbCount", bus.wbCount, 32'h0);
    idle();
    @(negedge clk);
    rst = 1'b0;

    // Table vectors: expected read-back pushed at drive time, popped after the edge.
    for (int i = 0; i < 8; i++) begin
      bus.regWrite = tbl[i].we;
      bus.rdAddr   = tbl[i].rd;
      bus.result   = tbl[i].dat;
      bus.rs1Addr  = tbl[i].a1;
      bus.rs2Addr  = tbl[i].a2;
      expq.push_back('{tbl[i].e1, tbl[i].e2, tbl[i].ecnt, i});
      step();
      if (expq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL vec%0d_queue: got empty expected entry", i);
      end else begin
        ex = expq.pop_front();
        chk($sformatf("vec%0d_rs1Data", ex.idx), bus.rs1Data, ex.e1);
        chk($sformatf("vec%0d_rs2Data", ex.idx), bus.rs2Data, ex.e2);
        chk($sformatf("vec%0d_wbCount", ex.idx), bus.wbCount, ex.ecnt);
      end
    end
    exp_cnt = tbl[7].ecnt;

    // x0: write dropped and uncounted, issue ignored.
    bus.rs1Addr = 5'd0;
    bus.rs2Addr = 5'd0;
    wb(5'd0, 32'h1234);
    issue(5'd0);
    step();
    chk("x0_rs1Data", bus.rs1Data, 32'h0);
    chk("x0_rs1Busy", 32'(bus.rs1Busy), 32'h0);
    chk("x0_wbCount", bus.wbCount, exp_cnt);

    // Saturate pend[7], attempt an illegal fourth issue, then drain with three writebacks.
    bus.rs1Addr = 5'd7;
    issue(5'd7); step();
    issue(5'd7); step();
    issue(5'd7); #1;
    chk("sat_stall_at2", 32'(bus.issueStall), 32'h0);
    step();
    issue(5'd7); #1;
    chk("sat_stall_at3", 32'(bus.issueStall), 32'h1);
    chk("sat_busy7", 32'(bus.rs1Busy), 32'h1);
    step();
    for (int k = 1; k <= 3; k++) begin
      wb(5'd7, 32'h700 + 32'(k));
      step();
      chk($sformatf("drain7_busy_w%0d", k), 32'(bus.rs1Busy), (k < 3) ? 32'h1 : 32'h0);
    end
    chk("drain7_data", bus.rs1Data, 32'h703);

    // Issue and writeback to the same register in one cycle leave the counter unchanged.
    bus.rs1Addr = 5'd9;
    issue(5'd9); step();
    issue(5'd9);
    wb(5'd9, 32'h99);
    step();
    chk("same9_busy", 32'(bus.rs1Busy), 32'h1);
    chk("same9_data", bus.rs1Data, 32'h99);
    wb(5'd9, 32'h9A);
    step();
    chk("same9_busy_clear", 32'(bus.rs1Busy), 32'h0);

    // Flush with concurrent writeback and issue; later writeback must not underflow.
    bus.rs1Addr = 5'd3;
    bus.rs2Addr = 5'd4;
    issue(5'd3); step();
    issue(5'd3); step();
    chk("fl_busy3_pre", 32'(bus.rs1Busy), 32'h1);
    wb(5'd3, 32'hA5);
    issue(5'd4);
    bus.flush = 1'b1;
    step();
    chk("fl_busy3", 32'(bus.rs1Busy), 32'h0);
    chk("fl_busy4", 32'(bus.rs2Busy), 32'h0);
    chk("fl_data3", bus.rs1Data, 32'hA5);
    chk("fl_wbCount", bus.wbCount, exp_cnt);
    wb(5'd3, 32'hB6);
    step();
    chk("fl_late_busy3", 32'(bus.rs1Busy), 32'h0);
    chk("fl_late_data3", bus.rs1Data, 32'hB6);
    issue(5'd3);
    step();
    chk("fl_reissue_busy3", 32'(bus.rs1Busy), 32'h1);
    wb(5'd3, 32'hC7);
    step();
    chk("fl_final_busy3", 32'(bus.rs1Busy), 32'h0);

    // Single outstanding write resolving on read port 2.
    bus.rs2Addr = 5'd12;
    wb(5'd12, 32'h11); step();
    issue(5'd12); step();
    chk("byp_busy_pre", 32'(bus.rs2Busy), 32'h1);
    wb(5'd12, 32'h55);
    #1;
`ifdef REGFILE_WB_BYPASS_EN
    chk("byp_same_data", bus.rs2Data, 32'h55);
    chk("byp_same_busy", 32'(bus.rs2Busy), 32'h0);
`else
    chk("byp_same_data", bus.rs2Data, 32'h11);
    chk("byp_same_busy", 32'(bus.rs2Busy), 32'h1);
`endif
    step();
    chk("byp_next_data", bus.rs2Data, 32'h55);
    chk("byp_next_busy", 32'(bus.rs2Busy), 32'h0);
    chk("byp_wbCount", bus.wbCount, exp_cnt);

    // Asynchronous reset in the middle of a cycle with a write and pending issue in flight.
    bus.rs1Addr = 5'd20;
    bus.rs2Addr = 5'd5;
    issue(5'd20); step();
    wb(5'd20, 32'h77); issue(5'd20); step();
    chk("mr_data_pre", bus.rs1Data, 32'h77);
    chk("mr_busy_pre", 32'(bus.rs1Busy), 32'h1);
    wb(5'd20, 32'h88);
    #2 rst = 1'b1;
    #1;
    chk("mr_rs1Data", bus.rs1Data, 32'h0);
    chk("mr_rs1Busy", 32'(bus.rs1Busy), 32'h0);
    chk("mr_wbCount", bus.wbCount, 32'h0);
    idle();
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("mr_post_data20", bus.rs1Data, 32'h0);
    chk("mr_post_data5", bus.rs2Data, 32'h0);
    chk("mr_post_busy20", 32'(bus.rs1Busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
Integer register file (32 x XLEN) that terminates the writeback interface: it consumes the write-enable, destination address and result produced by the writeback stage. It serves two combinational read ports to decode. It also holds a per-register pending-write scoreboard, which decode uses to detect RAW hazards, and a retired-write counter. It sits between the writeback stage (write side) and the decode/hazard logic (read side).

Parameters:
XLEN, 32, data width of each register and of result/read data
PEND_W, 2, width of each per-register pending-write counter (max in-flight writes per register = 2^PEND_W-1)
CNT_W, 32, width of the retired-write counter

Ports:
clk  input  1  core clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
regWrite  input  1  writeback write enable
rdAddr  input  5  writeback destination register
result  input  XLEN  writeback data
rs1Addr  input  5  read port 1 address
rs2Addr  input  5  read port 2 address
rs1Data  output  XLEN  read port 1 data (combinational)
rs2Data  output  XLEN  read port 2 data (combinational)
issueValid  input  1  decode issues an instruction that will write issueRd
issueRd  input  5  destination of the issuing instruction
flush  input  1  pipeline flush; discards all pending-write tracking
rs1Busy  output  1  rs1Addr has at least one pending write
rs2Busy  output  1  rs2Addr has at least one pending write
issueStall  output  1  pending counter for issueRd is saturated; issue must not occur
wbCount  output  CNT_W  number of committed writes to x1..x31 since reset

Behaviour:
- Reset (async, rst=1): all 32 registers = 0, all pending counters = 0, wbCount = 0. While reset is asserted: rs1Data/rs2Data = 0, rs1Busy/rs2Busy = 0, issueStall = 0. Reset mid-operation discards in-flight writes immediately.
- x0: reads always return 0 and busy is always 0. Writes to x0 are dropped and are not counted. Issue to x0 is ignored.
- Write: on a rising edge with regWrite=1 and rdAddr!=0, regs[rdAddr] <= result and wbCount <= wbCount+1. wbCount wraps modulo 2^CNT_W.
- Read: rsXData = regs[rsXAddr] asynchronously; both ports may address the same register.
- Scoreboard: pend[r] is updated every edge.
  - inc = issueValid && issueRd!=0 && !issueStall && !flush, with r=issueRd
  - dec = regWrite && rdAddr!=0 && pend[rdAddr]!=0, with r=rdAddr
  - inc and dec on the same r: counter unchanged. Otherwise +1 / -1.
  - Writeback to a register with pend=0 (e.g. after a flush) commits the data; the counter stays 0 and never underflows.
  - flush=1: all counters <= 0 on that edge. A concurrent writeback still commits its data and is counted; a concurrent issue is dropped.
- rsXBusy = (pend[rsXAddr]!=0) && rsXAddr!=0.
- issueStall = issueValid && issueRd!=0 && pend[issueRd]==2^PEND_W-1. Issue while issueStall is high is a protocol violation; the counter saturates and does not increment.
- Write-to-read latency: 1 cycle (the value is visible after the edge), unless bypass is enabled.

Optional Feature:
REGFILE_WB_BYPASS_EN
- Defined: when regWrite=1, rdAddr!=0 and rdAddr==rsXAddr, rsXData = result in the same cycle. rsXBusy is forced low if pend[rsXAddr]==1 and that write is occurring, so a single outstanding write resolves with zero bubble.
- Undefined: there is no bypass. Data and busy update one cycle after the write edge, and decode inserts one extra stall cycle.

Decomposition:
- Package core_pkg: XLEN, REG_ADDR_W=5, NUM_REGS=32, and a typedef for register address. The existing regSrc encodings ALU_SRC/MEM_SRC/PC_SRC move there too.
- Sub-module reg_scoreboard: holds the pend counter array, the inc/dec/flush logic and the busy/stall outputs.
- Storage, read muxes, bypass and wbCount stay in reg_file_wb.

Test Plan:
- Reset, then write x5=0xDEADBEEF; read rs1Addr=5 on the next cycle -> 0xDEADBEEF; wbCount=1.
- regWrite=1, rdAddr=0, result=0x1234 -> rs1Data at x0 stays 0; wbCount unchanged; issue to x0 -> busy stays 0.
- Issue rd=7 three times (PEND_W=2) -> rs1Busy=1 and issueStall=1 on a fourth issue of rd=7. Three writebacks to x7 -> busy clears after the third write.
- Issue rd=9 and writeback rd=9 in the same cycle with pend[9]=1 -> pend[9] stays 1, busy stays 1, regs[9] updated.
- Issue rd=3 twice, then flush with a concurrent writeback of x3=0xA5 and an issue of rd=4 -> all busy=0, regs[3]=0xA5, pend[4]=0. A later writeback to x3 does not underflow.
- With REGFILE_WB_BYPASS_EN: pend[12]=1, writeback x12=0x55 while rs2Addr=12 -> rs2Data=0x55 and rs2Busy=0 in the same cycle. Without the macro, the same stimulus gives the old data and busy=1 that cycle, and 0x55 with busy=0 the next cycle.
